// File: rtl/mux_sel_sweeper.sv
// rtl/mux_sel_sweeper.sv - select-code sweeper and truth-table checker for an 8:1 mux
module mux_sel_sweeper #(
    parameter int          SETTLE   = 1,
    parameter logic [7:0]  EXPECTED = 8'hC9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       mux_out,
    output logic       S0,
    output logic       S1,
    output logic       S2,
    output logic       busy,
    output logic [7:0] result,
    output logic       result_valid,
    input  logic       result_ready,
    output logic       mismatch,
    output logic [7:0] pass_cnt
);

    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

    localparam logic [3:0] SETTLE_H = 4'(SETTLE);

    state_t     state;
    logic [2:0] k;
    logic [3:0] h;
    logic [7:0] word;

    // Word as it stands once the current code's sample is folded in.
    always_comb begin
        word    = result;
        word[k] = mux_out;
    end

    // k is forced to 0 outside DRIVE, so the selects come straight from a register.
    assign {S2, S1, S0} = k;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            k            <= 3'd0;
            h            <= 4'd0;
            busy         <= 1'b0;
            result       <= 8'd0;
            result_valid <= 1'b0;
            mismatch     <= 1'b0;
            pass_cnt     <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        k      <= 3'd0;
                        h      <= 4'd0;
                        result <= 8'd0;
                        busy   <= 1'b1;
                        state  <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        k     <= 3'd0;
                        h     <= 4'd0;
                    end else if (h != SETTLE_H) begin
                        h <= h + 4'd1;
                    end else begin
                        h      <= 4'd0;
                        result <= word;
                        if (k != 3'd7) begin
                            k <= k + 3'd1;
                        end else begin
                            k            <= 3'd0;
                            state        <= DONE;
                            busy         <= 1'b0;
                            result_valid <= 1'b1;
                            mismatch     <= (word != EXPECTED);
                        end
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        mismatch     <= 1'b0;
                        state        <= IDLE;
                        if (!mismatch && pass_cnt != 8'd255) begin
                            pass_cnt <= pass_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_sel_sweeper.sv
// tb/tb_mux_sel_sweeper.sv - scoreboard bench for mux_sel_sweeper
module tb_mux_sel_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, abort, result_ready;
    logic [7:0] tbl;
    logic       mux_out, s0, s1, s2, busy, result_valid, mismatch;
    logic [7:0] result, pass_cnt;
    logic [2:0] sel;
    logic [7:0] good = 8'hC9;

    assign sel     = {s2, s1, s0};
    assign mux_out = tbl[sel];

    mux_sel_sweeper #(.SETTLE(1), .EXPECTED(8'hC9)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mux_out(mux_out),
        .S0(s0), .S1(s1), .S2(s2), .busy(busy), .result(result),
        .result_valid(result_valid), .result_ready(result_ready),
        .mismatch(mismatch), .pass_cnt(pass_cnt)
    );

    // Two extra instances cover the SETTLE timing extremes.
    logic       start_a;
    logic       a0_s0, a0_s1, a0_s2, a0_busy, a0_valid, a0_mm, a0_mux;
    logic       a3_s0, a3_s1, a3_s2, a3_busy, a3_valid, a3_mm, a3_mux;
    logic [7:0] a0_res, a0_pc, a3_res, a3_pc;
    assign a0_mux = good[{a0_s2, a0_s1, a0_s0}];
    assign a3_mux = good[{a3_s2, a3_s1, a3_s0}];

    mux_sel_sweeper #(.SETTLE(0), .EXPECTED(8'hC9)) aux0 (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(1'b0), .mux_out(a0_mux),
        .S0(a0_s0), .S1(a0_s1), .S2(a0_s2), .busy(a0_busy), .result(a0_res),
        .result_valid(a0_valid), .result_ready(1'b1), .mismatch(a0_mm), .pass_cnt(a0_pc)
    );
    mux_sel_sweeper #(.SETTLE(3), .EXPECTED(8'hC9)) aux3 (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(1'b0), .mux_out(a3_mux),
        .S0(a3_s0), .S1(a3_s1), .S2(a3_s2), .busy(a3_busy), .result(a3_res),
        .result_valid(a3_valid), .result_ready(1'b1), .mismatch(a3_mm), .pass_cnt(a3_pc)
    );

    int compared = 0;
    int failed   = 0;
    int model_pass = 0;

    typedef struct {
        logic [7:0] res;
        logic       mm;
    } exp_t;
    exp_t q[$];
    bit   seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare each new result against the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (result_valid && !seen) begin
            seen = 1'b1;
            if (q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = q.pop_front();
                check("result", result, e.res);
                check("mismatch", mismatch, e.mm);
            end
        end else if (!result_valid) begin
            seen = 1'b0;
        end
    end

    task automatic sweep(input logic [7:0] t, input int delay, input bit pre_ready, input bit poke);
        int         n, selerr, stab;
        logic [7:0] r0;
        exp_t       e;
        @(negedge clk);
        tbl = t; start = 1'b1; result_ready = pre_ready;
        e.res = t; e.mm = (t != 8'hC9);
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        n = 0; selerr = 0;
        while (!result_valid && n < 200) begin
            if (sel != 3'(n / 2)) selerr++;
            @(negedge clk);
            n++;
        end
        check("valid_latency", n, 16);
        check("sel_sequence", selerr, 0);
        check("busy_in_done", busy, 0);
        stab = 0; r0 = result;
        if (!pre_ready) begin
            repeat (delay) begin
                start = poke;
                @(negedge clk);
                start = 1'b0;
                if (!result_valid || result !== r0 || mismatch !== (t != 8'hC9) || busy) stab++;
            end
        end
        check("backpressure_stable", stab, 0);
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        if (t == 8'hC9 && model_pass < 255) model_pass++;
        check("valid_after_handshake", result_valid, 0);
        check("mismatch_after_handshake", mismatch, 0);
        check("pass_cnt", pass_cnt, model_pass);
        check("result_held", result, t);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t3, vcnt;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; result_ready = 1'b0;
        tbl = 8'hC9; start_a = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sel", sel, 0);
        check("rst_busy", busy, 0);
        check("rst_result", result, 0);
        check("rst_valid", result_valid, 0);
        check("rst_mismatch", mismatch, 0);
        check("rst_pass_cnt", pass_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);

        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        t0 = -1; t3 = -1;
        for (int n = 0; n < 60; n++) begin
            if (a0_valid && t0 < 0) begin t0 = n; check("settle0_result", a0_res, 8'hC9); end
            if (a3_valid && t3 < 0) begin t3 = n; check("settle3_result", a3_res, 8'hC9); end
            @(negedge clk);
        end
        check("settle0_latency", t0, 8);
        check("settle3_latency", t3, 32);

        sweep(8'hC9, 0, 1'b0, 1'b0);
        sweep(8'hC1, 2, 1'b0, 1'b0);
        sweep(8'hC9, 20, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            logic [7:0] rt;
            rt = ($urandom_range(0, 1) == 1) ? 8'hC9 : 8'($urandom);
            sweep(rt, $urandom_range(0, 5), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        tbl = 8'hC9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_code", sel, 4);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_sel", sel, 0);
        vcnt = 0;
        repeat (20) begin if (result_valid) vcnt++; @(negedge clk); end
        check("abort_no_valid", vcnt, 0);
        check("abort_pass_cnt", pass_cnt, model_pass);
        sweep(8'hC9, 1, 1'b0, 1'b0);

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_sel", sel, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_result", result, 0);
        check("async_rst_valid", result_valid, 0);
        check("async_rst_pass_cnt", pass_cnt, 0);
        model_pass = 0;
        @(negedge clk);
        rst_n = 1'b1;
        vcnt = 0;
        repeat (25) begin if (result_valid) vcnt++; @(negedge clk); end
        check("rst_no_valid", vcnt, 0);

        for (int i = 0; i < 256; i++) sweep(8'hC9, 0, 1'($urandom_range(0, 1)), 1'b0);
        check("pass_cnt_saturated", pass_cnt, 255);
        check("scoreboard_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
